// File: rtl/clock_set_ctrl.sv
// Time-setting controller: RUN/SET_H/SET_M/SET_S editor with
// auto-repeat increment, load/hold handshake and multiplexed display.
module clock_set_ctrl #(
  parameter int SCAN_DIV   = 4,
  parameter int BLINK_DIV  = 64,
  parameter int REPEAT_DLY = 32,
  parameter int REPEAT_PER = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  output logic       hold,
  output logic       load,
  output logic [4:0] set_hours,
  output logic [5:0] set_minutes,
  output logic [5:0] set_seconds,
  output logic [1:0] mode,
  output logic [7:0] disp,
  output logic [1:0] disp_sel
);

  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ?
                        REPEAT_DLY : REPEAT_PER;
  localparam int RW = $clog2(RMAX + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic          mode_prev, inc_prev;
  logic          mode_edge, inc_edge;
  logic          load_q;
  logic [RW-1:0] rpt_cnt, rpt_thr;
  logic          rpt_on;
  logic          inc_fire;
  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase, blink_nxt;
  logic [1:0]    sel_nxt;
  logic [7:0]    disp_nxt;
  logic [4:0]    src_h;
  logic [5:0]    src_m, src_s;

  assign mode_edge = btn_mode & ~mode_prev;
  assign inc_edge  = btn_inc & ~inc_prev;
  assign rpt_thr   = rpt_on ? RW'(REPEAT_PER) : RW'(REPEAT_DLY);
  assign mode      = state;
  assign load      = load_q;
  assign hold      = (state != RUN) | load_q;

  always_comb begin
    state_nxt = state;
    if (mode_edge) begin
      unique case (state)
        RUN:   state_nxt = SET_H;
        SET_H: state_nxt = SET_M;
        SET_M: state_nxt = SET_S;
        SET_S: state_nxt = RUN;
      endcase
    end
  end

  // A mode edge wins over any increment in the same cycle
  always_comb begin
    inc_fire = 1'b0;
    if (state != RUN && !mode_edge) begin
      if (inc_edge)
        inc_fire = 1'b1;
      else if (btn_inc && rpt_cnt != '0 && rpt_cnt == rpt_thr)
        inc_fire = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      mode_prev <= 1'b1;
      inc_prev  <= 1'b1;
      load_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      mode_prev <= btn_mode;
      inc_prev  <= btn_inc;
      load_q    <= (state == SET_S) && (state_nxt == RUN);
    end
  end

  // rpt_cnt == 0 means idle; otherwise it counts cycles toward rpt_thr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt <= '0;
      rpt_on  <= 1'b0;
    end else if (state == RUN || mode_edge || !btn_inc) begin
      rpt_cnt <= '0;
      rpt_on  <= 1'b0;
    end else if (inc_edge) begin
      rpt_cnt <= RW'(1);
      rpt_on  <= 1'b0;
    end else if (rpt_cnt != '0) begin
      if (rpt_cnt == rpt_thr) begin
        rpt_cnt <= RW'(1);
        rpt_on  <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_hours   <= '0;
      set_minutes <= '0;
      set_seconds <= '0;
    end else if (state == RUN && mode_edge) begin
      set_hours   <= (cur_hours > 5'd23)   ? '0 : cur_hours;
      set_minutes <= (cur_minutes > 6'd59) ? '0 : cur_minutes;
      set_seconds <= (cur_seconds > 6'd59) ? '0 : cur_seconds;
    end else if (inc_fire) begin
      unique case (state)
        SET_H: set_hours <= (set_hours >= 5'd23) ?
                            '0 : set_hours + 5'd1;
        SET_M: set_minutes <= (set_minutes >= 6'd59) ?
                              '0 : set_minutes + 6'd1;
        SET_S: set_seconds <= (set_seconds >= 6'd59) ?
                              '0 : set_seconds + 6'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    sel_nxt   = disp_sel;
    blink_nxt = blink_phase;
    if (scan_cnt == SW'(SCAN_DIV - 1))
      sel_nxt = (disp_sel == 2'd2) ? 2'd0 : disp_sel + 2'd1;
    if (blink_cnt == BW'(BLINK_DIV - 1))
      blink_nxt = ~blink_phase;
  end

  always_comb begin
    src_h    = (state == RUN) ? cur_hours   : set_hours;
    src_m    = (state == RUN) ? cur_minutes : set_minutes;
    src_s    = (state == RUN) ? cur_seconds : set_seconds;
    disp_nxt = 8'd0;
    unique case (sel_nxt)
      2'd0: if (!(blink_nxt && state == SET_H))
              disp_nxt = {3'b0, src_h};
      2'd1: if (!(blink_nxt && state == SET_M))
              disp_nxt = {2'b0, src_m};
      2'd2: if (!(blink_nxt && state == SET_S))
              disp_nxt = {2'b0, src_s};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      disp_sel    <= '0;
      disp        <= '0;
    end else begin
      scan_cnt    <= (scan_cnt == SW'(SCAN_DIV - 1)) ?
                     '0 : scan_cnt + SW'(1);
      blink_cnt   <= (blink_cnt == BW'(BLINK_DIV - 1)) ?
                     '0 : blink_cnt + BW'(1);
      blink_phase <= blink_nxt;
      disp_sel    <= sel_nxt;
      disp        <= disp_nxt;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed testbench for clock_set_ctrl with default parameters.
module tb_clock_set_ctrl;

  logic       clk, rst;
  logic       btn_mode, btn_inc;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes, cur_seconds;
  logic       hold, load;
  logic [4:0] set_hours;
  logic [5:0] set_minutes, set_seconds;
  logic [1:0] mode;
  logic [7:0] disp;
  logic [1:0] disp_sel;

  int tests, fails;

  clock_set_ctrl dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes),
    .cur_seconds(cur_seconds),
    .hold(hold), .load(load),
    .set_hours(set_hours), .set_minutes(set_minutes),
    .set_seconds(set_seconds),
    .mode(mode), .disp(disp), .disp_sel(disp_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press_mode;
    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
    tick();
  endtask

  task automatic press_inc;
    btn_inc = 1'b1;
    tick();
    btn_inc = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    cur_hours = 5'd0;
    cur_minutes = 6'd0;
    cur_seconds = 6'd0;
    tick(3);
    tests++;
    if ({mode, hold, load, set_hours, set_minutes, set_seconds,
         disp, disp_sel} !== '0) begin
      fails++;
      $display("FAIL reset_state: mode=%0d hold=%0d load=%0d set=%0d:%0d:%0d disp=%0d sel=%0d expected all 0",
               mode, hold, load, set_hours, set_minutes,
               set_seconds, disp, disp_sel);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_mode_cycle;
    cur_hours = 5'd12;
    cur_minutes = 6'd34;
    cur_seconds = 6'd56;
    press_mode();
    chk("enter_seth_mode", mode, 1);
    chk("enter_seth_hold", hold, 1);
    chk("capture_set", {set_hours, set_minutes, set_seconds},
        {5'd12, 6'd34, 6'd56});
    press_mode();
    chk("setm_mode", mode, 2);
    chk("setm_load", load, 0);
    press_mode();
    chk("sets_mode", mode, 3);
    chk("sets_hold", hold, 1);
    btn_mode = 1'b1;
    tick();
    chk("run_mode", mode, 0);
    chk("load_pulse", load, 1);
    chk("hold_extra_cycle", hold, 1);
    chk("load_value", {set_hours, set_minutes, set_seconds},
        {5'd12, 6'd34, 6'd56});
    btn_mode = 1'b0;
    tick();
    chk("load_drop", load, 0);
    chk("hold_drop", hold, 0);
  endtask

  task automatic test_wrap;
    cur_hours = 5'd23;
    cur_minutes = 6'd59;
    cur_seconds = 6'd0;
    press_mode();
    chk("wrap_capture_h", set_hours, 23);
    press_inc();
    chk("wrap_hours", set_hours, 0);
    chk("wrap_min_untouched", set_minutes, 59);
    press_mode();
    press_inc();
    chk("wrap_minutes", set_minutes, 0);
    chk("wrap_hours_kept", set_hours, 0);
  endtask

  task automatic test_repeat;
    press_mode();
    chk("rpt_mode", mode, 3);
    chk("rpt_start", set_seconds, 0);
    btn_inc = 1'b1;
    tick();
    chk("rpt_edge", set_seconds, 1);
    tick(31);
    chk("rpt_before_dly", set_seconds, 1);
    tick();
    chk("rpt_at_dly", set_seconds, 2);
    tick(23);
    chk("rpt_after_56", set_seconds, 4);
    btn_inc = 1'b0;
    tick(20);
    chk("rpt_released", set_seconds, 4);
    btn_inc = 1'b1;
    tick(5);
    press_mode();
    btn_inc = 1'b0;
    tick(40);
    chk("rpt_cleared_on_mode", set_seconds, 5);
    chk("rpt_back_run", mode, 0);
    btn_inc = 1'b1;
    tick(3);
    btn_inc = 1'b0;
    tick();
    chk("inc_ignored_run", set_seconds, 5);
  endtask

  task automatic test_clamp;
    cur_hours = 5'd24;
    cur_minutes = 6'd60;
    cur_seconds = 6'd63;
    press_mode();
    chk("clamp_hours", set_hours, 0);
    chk("clamp_minutes", set_minutes, 0);
    chk("clamp_seconds", set_seconds, 0);
    press_mode();
    press_mode();
    press_mode();
    chk("clamp_exit", mode, 0);
  endtask

  task automatic test_simultaneous;
    cur_hours = 5'd5;
    cur_minutes = 6'd10;
    cur_seconds = 6'd20;
    press_mode();
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    tick();
    chk("simul_mode", mode, 2);
    chk("simul_hours", set_hours, 5);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    tick();
    chk("simul_minutes", set_minutes, 10);
    press_mode();
    press_mode();
  endtask

  task automatic test_display;
    logic [1:0] s0;
    int i0;
    int exp_sel, exp_d;
    logic [1:0] sel_log [24];
    logic [7:0] d_log [24];
    cur_hours = 5'd7;
    cur_minutes = 6'd42;
    cur_seconds = 6'd13;
    tick(2);
    for (int k = 0; k < 24; k++) begin
      sel_log[k] = disp_sel;
      d_log[k] = disp;
      tick();
    end
    i0 = 0;
    for (int k = 1; k < 6; k++)
      if (i0 == 0 && sel_log[k] != sel_log[k-1]) i0 = k;
    s0 = sel_log[i0];
    for (int k = i0; k < 24; k++) begin
      exp_sel = (int'(s0) + (k - i0) / 4) % 3;
      chk("scan_sel", int'(sel_log[k]), exp_sel);
    end
    for (int k = 0; k < 24; k += 3) begin
      exp_d = (sel_log[k] == 2'd0) ? 7 :
              (sel_log[k] == 2'd1) ? 42 : 13;
      chk("run_disp", int'(d_log[k]), exp_d);
    end
  endtask

  task automatic test_blink;
    int blanks, shows, bad;
    blanks = 0;
    shows = 0;
    bad = 0;
    press_mode();
    for (int k = 0; k < 160; k++) begin
      if (disp_sel == 2'd0) begin
        if (disp == 8'd0) blanks++;
        else if (disp == 8'd7) shows++;
        else bad++;
      end else if (disp_sel == 2'd1) begin
        if (disp != 8'd42) bad++;
      end
      tick();
    end
    chk("blink_bad_values", bad, 0);
    chk("blink_seen_blank", int'(blanks > 0), 1);
    chk("blink_seen_value", int'(shows > 0), 1);
    press_mode();
    press_mode();
    press_mode();
  endtask

  task automatic test_reset_mid;
    int loads;
    loads = 0;
    press_mode();
    press_mode();
    chk("mid_in_setm", mode, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_mode_async", mode, 0);
    chk("mid_hold_async", hold, 0);
    chk("mid_load_async", load, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (load !== 1'b0 || hold !== 1'b0) loads++;
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (load !== 1'b0 || hold !== 1'b0) loads++;
    end
    chk("mid_no_load_after", loads, 0);
    chk("mid_set_cleared", set_minutes, 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_mode_cycle();
    test_wrap();
    test_repeat();
    test_clamp();
    test_simultaneous();
    test_display();
    test_blink();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: clk cycles per display-select step.
REQ-002 SHALL have parameter BLINK_DIV, default 64: clk cycles per blink-phase toggle.
REQ-003 SHALL have parameter REPEAT_DLY, default 32: cycles btn_inc is held before auto-repeat starts.
REQ-004 SHALL have parameter REPEAT_PER, default 8: cycles between auto-repeat increments.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports btn_mode, btn_inc  input  1 each  debounced buttons, synchronous to clk, active-high.
REQ-008 SHALL have ports cur_hours  input  5, cur_minutes  input  6, cur_seconds  input  6  live counter values from the time-keeping datapath.
REQ-009 SHALL have port hold  output  1  freezes the time-keeping counters while high.
REQ-010 SHALL have port load  output  1  one-cycle pulse that commits set_* into the counters.
REQ-011 SHALL have ports set_hours  output  5, set_minutes  output  6, set_seconds  output  6  shadow (edit) values.
REQ-012 SHALL have port mode  output  2  0=RUN, 1=SET_H, 2=SET_M, 3=SET_S.
REQ-013 SHALL have ports disp  output  8  and disp_sel  output  2  multiplexed display byte and field index.

Function
REQ-014 SHALL detect button presses as rising edges against a registered previous value; previous-value registers reset to 1, so a button held through reset release yields no edge.
REQ-015 SHALL implement FSM RUN -> SET_H -> SET_M -> SET_S -> RUN, advancing one state per btn_mode edge.
REQ-016 SHALL, on RUN->SET_H, capture cur_* into set_* in the same edge; a captured hours value >23 or minutes/seconds value >59 is clamped to 0.
REQ-017 SHALL drive hold=1 in SET_H, SET_M and SET_S, and for the first RUN cycle after SET_S.
REQ-018 SHALL, on SET_S->RUN, assert load=1 for exactly that first RUN cycle; hold falls the following cycle; load is never asserted otherwise.
REQ-019 SHALL, on a btn_inc edge in SET_x, increment only field x: hours wrap 23->0, minutes and seconds wrap 59->0.
REQ-020 SHALL, while btn_inc stays high in the same SET state, issue a further increment after REPEAT_DLY cycles, then one every REPEAT_PER cycles until release; the repeat counter clears on release or on any state change.
REQ-021 SHALL ignore btn_inc in RUN.
REQ-022 SHALL, on simultaneous btn_mode and btn_inc edges, take the mode transition and discard the increment.
REQ-023 SHALL step disp_sel 0->1->2->0 every SCAN_DIV cycles; the value 3 never occurs.
REQ-024 SHALL register disp = {3'b0,hours} for sel 0, {2'b0,minutes} for sel 1, {2'b0,seconds} for sel 2; the source is cur_* in RUN and set_* in the SET states.
REQ-025 SHALL toggle blink_phase every BLINK_DIV cycles; while in SET_x with blink_phase=1, disp shows 0 when disp_sel selects field x.
REQ-026 SHALL keep the scan and blink counters free-running across mode changes.

Reset
REQ-027 SHALL, while rst is high, force mode=RUN, hold=0, load=0, set_*=0, disp=0, disp_sel=0, blink_phase=0, and all internal counters to 0.
REQ-028 SHALL, on reset asserted mid-edit, abandon the edit: no load pulse, and hold falls immediately (asynchronously).

Verification
REQ-029 SHALL cover: cur=12:34:56, four btn_mode edges with no btn_inc -> mode steps 1,2,3,0; single load pulse with set=12:34:56; hold high for 3 states plus 1 cycle.
REQ-030 SHALL cover: in SET_H with set_hours=23, one btn_inc edge -> set_hours=0; in SET_M with 59, one edge -> set_minutes=0.
REQ-031 SHALL cover: SET_S, btn_inc held 56 cycles with defaults -> seconds incremented 4 times (edge, +32, +40, +48).
REQ-032 SHALL cover: cur_hours=24 at mode entry -> set_hours=0.
REQ-033 SHALL cover: same-cycle btn_mode and btn_inc edges in SET_H -> mode=SET_M, set_hours unchanged.
REQ-034 SHALL cover: rst asserted in SET_M -> mode=0, hold=0 at once; load stays 0 through and after release.
